// File: rtl/fetch_unit.sv
// Single-stage instruction fetch in front of a synchronous instruction memory.
// It issues one word address per cycle and presents the returned word, with its PC, to the decoder.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst,
    output logic        inst_valid,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus1
);

    // Control priority, highest first: rst, then redirect_valid, then stall.
    // A stall re-issues rpc, so the memory returns the same word again on the next cycle.
    // A redirect flushes the word returned in that cycle. The target word arrives one cycle later.
    logic [15:0] fpc;
    logic [15:0] rpc;
    logic        rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc    <= RESET_PC;
            rpc    <= 16'h0000;
            rvalid <= 1'b0;
        end else if (redirect_valid) begin
            rpc    <= redirect_pc;
            rvalid <= 1'b1;
            fpc    <= redirect_pc + 16'd1;
        end else if (!stall) begin
            rpc    <= fpc;
            rvalid <= 1'b1;
            fpc    <= fpc + 16'd1;
        end
    end

    always_comb begin
        imem_addr = fpc;
        if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else if (stall) begin
            imem_addr = rpc;
        end
    end

    assign inst_valid = rvalid & ~redirect_valid;
    assign inst       = inst_valid ? imem_rdata : NOP_INST;
    assign pc_out     = rpc;
    assign pc_plus1   = rpc + 16'd1;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A directed vector table covers reset, stall, redirect and wrap behaviour.
// A random stall/redirect run follows, checked against an in-order expected-PC queue.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc_out;
    logic [15:0] pc_plus1;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .pc_out(pc_out), .pc_plus1(pc_plus1)
    );

    // clock / reset block
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h5000 + a;
    endfunction

    // synchronous memory model: word for last cycle's address
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        chk;
        logic        rst;
        logic        stall;
        logic        rv;
        logic [15:0] rpc;
        logic        e_valid;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic chk, input logic r, input logic s, input logic rv, input logic [15:0] rp,
                       input logic ev, input logic [15:0] ei, input logic [15:0] ep, input logic [15:0] ea);
        vec_t v;
        v.chk = chk; v.rst = r; v.stall = s; v.rv = rv; v.rpc = rp;
        v.e_valid = ev; v.e_inst = ei; v.e_pc = ep; v.e_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [15:0] rp);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        #1;
    endtask

    initial begin
        logic [15:0] e;
        //   chk rst stl rv  rpc       valid inst      pc        addr
        add(0, 1, 0, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000); // first cycle after reset
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5000, 16'h0000, 16'h0001);
        add(1, 0, 1, 0, 16'h0000, 1, 16'h5001, 16'h0001, 16'h0001); // stall x3 on pc 1
        add(1, 0, 1, 0, 16'h0000, 1, 16'h5001, 16'h0001, 16'h0001);
        add(1, 0, 1, 0, 16'h0000, 1, 16'h5001, 16'h0001, 16'h0001);
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5001, 16'h0001, 16'h0002);
        add(1, 0, 0, 1, 16'h0040, 0, NOP,      16'h0002, 16'h0040); // redirect while presenting pc 2
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5040, 16'h0040, 16'h0041);
        add(1, 0, 1, 1, 16'h0100, 0, NOP,      16'h0041, 16'h0100); // redirect beats stall
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5100, 16'h0100, 16'h0101);
        add(1, 0, 0, 1, 16'hFFFF, 0, NOP,      16'h0101, 16'hFFFF); // wrap target
        add(1, 0, 0, 0, 16'h0000, 1, 16'h4FFF, 16'hFFFF, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5000, 16'h0000, 16'h0001);
        for (int i = 1; i <= 6; i++)
            add(1, 0, 0, 0, 16'h0000, 1, 16'h5000 + 16'(i), 16'(i), 16'(i + 1));
        add(1, 0, 1, 0, 16'h0000, 1, 16'h5007, 16'h0007, 16'h0007); // stall at pc 7
        add(1, 1, 1, 0, 16'h0000, 1, 16'h5007, 16'h0007, 16'h0007); // reset mid-stall
        add(1, 0, 0, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5000, 16'h0000, 16'h0001);
        add(1, 1, 0, 0, 16'h0000, 1, 16'h5001, 16'h0001, 16'h0002);
        add(1, 0, 1, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000); // stall with nothing valid
        add(1, 0, 1, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000);
        add(1, 0, 0, 0, 16'h0000, 1, 16'h5000, 16'h0000, 16'h0001);
        add(1, 1, 0, 1, 16'h0300, 0, NOP,      16'h0001, 16'h0300); // reset mid-redirect
        add(1, 0, 0, 0, 16'h0000, 0, NOP,      16'h0000, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            if (vecs[i].chk) begin
                check("inst_valid", i, 16'(inst_valid), 16'(vecs[i].e_valid));
                check("inst", i, inst, vecs[i].e_inst);
                check("pc_out", i, pc_out, vecs[i].e_pc);
                check("pc_plus1", i, pc_plus1, vecs[i].e_pc + 16'd1);
                check("imem_addr", i, imem_addr, vecs[i].e_addr);
            end
        end

        // random run: from here every cycle presents a valid word unless redirected
        exp_q.push_back(16'h0000);
        for (int n = 0; n < 300; n++) begin
            drive(1'b0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 16'($urandom_range(0, 65535)));
            if (redirect_valid) begin
                check("rnd_flush_valid", n, 16'(inst_valid), 16'h0000);
                check("rnd_flush_inst", n, inst, NOP);
                check("rnd_redir_addr", n, imem_addr, redirect_pc);
                exp_q.delete();
                exp_q.push_back(redirect_pc);
            end else if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rnd_queue [%0d]: got empty queue expected one entry", n);
            end else begin
                e = exp_q[0];
                check("rnd_valid", n, 16'(inst_valid), 16'h0001);
                check("rnd_pc", n, pc_out, e);
                check("rnd_inst", n, inst, mem_word(e));
                check("rnd_pc_plus1", n, pc_plus1, e + 16'd1);
                if (stall) begin
                    check("rnd_stall_addr", n, imem_addr, e);
                end else begin
                    check("rnd_addr", n, imem_addr, e + 16'd1);
                    void'(exp_q.pop_front());
                    exp_q.push_back(e + 16'd1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: word address of the first instruction fetched after reset.
REQ-002 Parameter NOP_INST, default 16'h0020: bubble word driven to the decoder when no valid instruction is present.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold request from downstream hazard logic; freeze fetch and the presented instruction.
REQ-007 redirect_valid  input  1  taken jump/branch from execute; flush and refetch.
REQ-008 redirect_pc  input  16  word address of the redirect target.
REQ-009 imem_addr  output  16  word address to synchronous instruction memory.
REQ-010 imem_rdata  input  16  memory word for the address presented one cycle earlier.
REQ-011 inst  output  16  instruction word to the decoder.
REQ-012 inst_valid  output  1  inst is a real, non-flushed instruction.
REQ-013 pc_out  output  16  word address of inst.
REQ-014 pc_plus1  output  16  pc_out+1, link value for JAL.

Function
REQ-015 State SHALL be three registers: fpc (next address to issue, 16b), rpc (address issued last cycle, 16b), rvalid (last issue valid, 1b).
REQ-016 imem_addr SHALL be redirect_pc if redirect_valid, else rpc if stall, else fpc (combinational).
REQ-017 inst_valid SHALL equal rvalid AND NOT redirect_valid (combinational flush of the wrong-path word).
REQ-018 inst SHALL equal imem_rdata when inst_valid=1, else NOP_INST.
REQ-019 pc_out SHALL equal rpc; pc_plus1 SHALL equal rpc+1 modulo 2^16.
REQ-020 Redirect cycle (redirect_valid=1, priority over stall): rpc<=redirect_pc, rvalid<=1, fpc<=redirect_pc+1.
REQ-021 Stall cycle (stall=1, redirect_valid=0): rpc, rvalid, fpc SHALL hold; re-reading rpc makes the same word reappear next cycle.
REQ-022 Normal cycle: rpc<=fpc, rvalid<=1, fpc<=fpc+1.
REQ-023 Fetch latency SHALL be exactly one cycle from imem_addr to a valid inst; throughput one instruction per unstalled cycle.
REQ-024 Redirect penalty SHALL be one bubble: inst_valid=0 in the redirect cycle, target instruction valid in the next cycle.
REQ-025 All PC arithmetic SHALL be 16-bit unsigned, wrapping 16'hFFFF -> 16'h0000 with no flag.
REQ-026 Stall asserted with rvalid=0 SHALL keep inst_valid=0 and inst=NOP_INST.
REQ-027 Memory contents are not written during a stall; re-fetch coherence is guaranteed only under that condition.

Reset
REQ-028 rst=1 at a clock edge SHALL set fpc<=RESET_PC, rpc<=16'h0000, rvalid<=0, overriding stall and redirect_valid.
REQ-029 In the first cycle after reset: imem_addr=RESET_PC, inst_valid=0, inst=NOP_INST, pc_out=16'h0000.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard that operation with no residual effect.

Verification
REQ-031 Reset then 4 free cycles with mem[i]=16'h5000+i -> cycle 1 invalid/NOP; cycles 2-4 inst=5000,5001,5002 with pc_out=0,1,2 and pc_plus1=1,2,3.
REQ-032 Stall for 3 cycles while inst=5001 (pc_out=1) -> inst=5001, pc_out=1, inst_valid=1 throughout; after release inst=5002, then 5003.
REQ-033 redirect_valid=1, redirect_pc=16'h0040 while presenting pc 2 -> that cycle inst_valid=0, inst=0020, imem_addr=0040; next cycle pc_out=0040, inst=mem[40]; then 0041.
REQ-034 redirect_valid and stall both 1 -> redirect wins: next cycle pc_out=redirect_pc, inst_valid=1.
REQ-035 redirect_pc=16'hFFFF -> pc_out=FFFF with pc_plus1=0000; next unstalled cycle pc_out=0000.
REQ-036 rst=1 during a stall at pc_out=7 -> next cycle inst_valid=0, imem_addr=RESET_PC; stream restarts from RESET_PC.
